// File: rtl/pulse_event_arbiter_pkg.sv
// Shared types and helpers for pulse_event_arbiter.
// Provides the one-hot FSM state encoding, the bit index of the IDLE state
// (used to derive busy), and a small max helper for counter sizing.
package pulse_event_arbiter_pkg;

  localparam int ST_IDLE_B = 0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LAUNCH = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_COOL   = 4'b1000
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_event_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set bit of i_pend strictly after i_ptr, wrapping from
// NUM_REQ-1 to 0; i_ptr itself has the lowest priority.
// Ports:
//   i_pend     pending request bits
//   i_ptr      id of the last granted requester
//   o_gnt_vld  at least one bit pending
//   o_gnt_id   selected requester id
module pulse_event_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_pend,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_gnt_vld,
  output logic [ID_W-1:0]    o_gnt_id
);

  int w_idx;

  // Scan from farthest to nearest so the nearest pending bit after the
  // pointer is the last (winning) assignment.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_id  = '0;
    w_idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (i_pend[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Shares one pulse CDC channel among NUM_REQ event sources.
// Request pulses are latched as pending bits, granted round-robin, and each
// grant launches one channel pulse with the requester id held on o_ch_id
// until the return ack (or a timeout), followed by a cooldown.
// Ports:
//   i_clk, i_rst_n  source clock, async active-low reset
//   i_req_pulse     one-cycle event per requester
//   o_pend          registered pending bits
//   o_ch_pulse      channel launch pulse, one cycle per grant
//   o_ch_id         granted id, stable from launch until ack/timeout
//   i_ch_ack        synchronized return pulse from the destination
//   o_busy          FSM not idle
//   o_merge         request hit an already-pending bit (1-cycle pulse)
//   o_tmo_err       ack timeout (1-cycle pulse)
module pulse_event_arbiter
  import pulse_event_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int TMO_W    = 8,
  parameter int TMO_CYC  = 200,
  parameter int COOL_CYC = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req_pulse,
  output logic [NUM_REQ-1:0] o_pend,
  output logic               o_ch_pulse,
  output logic [ID_W-1:0]    o_ch_id,
  input  logic               i_ch_ack,
  output logic               o_busy,
  output logic               o_merge,
  output logic               o_tmo_err
);

  // One counter serves both the ack timeout and the cooldown.
  localparam int CNT_W     = max2(TMO_W, $clog2(COOL_CYC + 1));
  // The counter holds the number of cycles since the launch pulse, so the
  // timeout pulse lands exactly TMO_CYC cycles after o_ch_pulse.
  localparam int TMO_LAST  = (TMO_CYC > 1) ? TMO_CYC - 1 : 1;
  localparam int COOL_LAST = COOL_CYC - 1;

  state_e             r_state;
  logic [NUM_REQ-1:0] r_pend;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_ch_id;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ch_pulse;
  logic               r_merge;
  logic               r_tmo_err;

  logic               w_gnt_vld;
  logic [ID_W-1:0]    w_gnt_id;
  logic [NUM_REQ-1:0] w_clr;

  pulse_event_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_pend    (r_pend),
    .i_ptr     (r_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  always_comb begin
    w_clr = '0;
    if (r_state == ST_IDLE && w_gnt_vld) w_clr[w_gnt_id] = 1'b1;
  end

  // Set beats clear: a request arriving on the grant cycle stays queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= '0;
      r_merge <= 1'b0;
    end else begin
      r_pend  <= (r_pend & ~w_clr) | i_req_pulse;
      r_merge <= |(i_req_pulse & r_pend & ~w_clr);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_ch_id    <= '0;
      r_cnt      <= '0;
      r_ch_pulse <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_ch_pulse <= 1'b0;
      r_tmo_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_state    <= ST_LAUNCH;
            r_ch_id    <= w_gnt_id;
            r_ptr      <= w_gnt_id;
            r_ch_pulse <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= CNT_W'(1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ack has priority over a timeout in the same cycle.
          if (i_ch_ack) begin
            r_state <= ST_COOL;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(TMO_LAST)) begin
            r_state   <= ST_COOL;
            r_cnt     <= '0;
            r_tmo_err <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_COOL: begin
          if (r_cnt == CNT_W'(COOL_LAST)) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pend     = r_pend;
  assign o_ch_pulse = r_ch_pulse;
  assign o_ch_id    = r_ch_id;
  assign o_busy     = ~r_state[ST_IDLE_B];
  assign o_merge    = r_merge;
  assign o_tmo_err  = r_tmo_err;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
module tb_pulse_event_arbiter;

  localparam int NR   = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 20;
  localparam int COOL = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic          ack;
  logic [NR-1:0] o_pend;
  logic          o_ch_pulse;
  logic [IDW-1:0] o_ch_id;
  logic          o_busy, o_merge, o_tmo_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  always #5 clk = ~clk;

  pulse_event_arbiter #(
    .NUM_REQ(NR), .ID_W(IDW), .TMO_W(8), .TMO_CYC(TMO), .COOL_CYC(COOL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_pulse(req),
    .o_pend(o_pend), .o_ch_pulse(o_ch_pulse), .o_ch_id(o_ch_id),
    .i_ch_ack(ack), .o_busy(o_busy), .o_merge(o_merge), .o_tmo_err(o_tmo_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-stamp view of the channel: phase 0 idle, 1 in flight (launched at
  // period m_tl), 2 cooling until period m_ti.
  logic [NR-1:0] m_pend, m_clr;
  int m_ptr, m_id, m_phase, m_n, m_tl, m_ti, m_g;
  logic m_pulse, m_merge, m_tmo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_ptr = NR - 1; m_id = 0; m_phase = 0; m_n = 0;
      m_tl = -100; m_ti = 0; m_pulse = 0; m_merge = 0; m_tmo = 0;
    end else begin
      m_n++;
      m_clr = '0;
      m_tmo = 0;
      if (m_phase == 0) begin
        if (m_pend != 0) begin
          m_g = -1;
          for (int k = 1; k <= NR; k++)
            if (m_g < 0 && m_pend[(m_ptr + k) % NR]) m_g = (m_ptr + k) % NR;
          m_clr[m_g] = 1'b1;
          m_ptr = m_g; m_id = m_g; m_phase = 1; m_tl = m_n;
        end
      end else if (m_phase == 1) begin
        if (m_n - 1 > m_tl && ack) begin
          m_phase = 2; m_ti = m_n + COOL;
        end else if (m_n == m_tl + TMO) begin
          m_tmo = 1; m_phase = 2; m_ti = m_n + COOL;
        end
      end else if (m_n == m_ti) begin
        m_phase = 0;
      end
      m_merge = |(req & m_pend & ~m_clr);
      m_pend  = (m_pend & ~m_clr) | req;
      m_pulse = (m_phase == 1 && m_n == m_tl);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1)
      chk("model", {o_pend, o_ch_pulse, o_ch_id, o_busy, o_merge, o_tmo_err},
          {m_pend, m_pulse, 2'(m_id), (m_phase != 0), m_merge, m_tmo});
    if (o_ch_pulse === 1'b1) n_pulses++;
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_req(input logic [NR-1:0] v);
    req = v;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_pulse(output int t);
    t = 0;
    while (o_ch_pulse !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("pulse_seen", (t < 500), 1);
  endtask

  task automatic grant(input int exp_id, input int dly);
    int t;
    wait_pulse(t);
    chk("grant_id", o_ch_id, exp_id);
    @(negedge clk);
    repeat (dly) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  typedef struct packed {
    logic [NR-1:0]  req;
    logic           ack;
    logic [NR-1:0]  pend;
    logic           pulse;
    logic [IDW-1:0] id;
    logic           busy;
    logic           merge;
    logic           tmo;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int t, tc, p0;
    for (int k = 0; k < 20; k++) tbl[k] = '0;
    tbl[0].req = 4'b0001;
    tbl[1].pend = 4'b0001;
    tbl[2].pulse = 1'b1;
    for (int k = 2; k < 19; k++) tbl[k].busy = 1'b1;
    tbl[12].ack = 1'b1;

    rst_n = 1'b0; req = '0; ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {o_pend, o_ch_pulse, o_ch_id, o_busy, o_merge, o_tmo_err}, 0);
    rst_n = 1'b1;

    // 1: single request, ack 10 cycles after launch, cooldown
    for (int k = 0; k < 20; k++) begin
      chk("t1_pend",  o_pend,     tbl[k].pend);
      chk("t1_pulse", o_ch_pulse, tbl[k].pulse);
      chk("t1_id",    o_ch_id,    tbl[k].id);
      chk("t1_busy",  o_busy,     tbl[k].busy);
      chk("t1_merge", o_merge,    tbl[k].merge);
      chk("t1_tmo",   o_tmo_err,  tbl[k].tmo);
      req = tbl[k].req; ack = tbl[k].ack;
      @(negedge clk);
    end
    req = '0; ack = 1'b0;

    // 2: all four at once, then pointer wrap
    do_reset();
    pulse_req(4'b1111);
    for (int i = 0; i < 4; i++) grant(i, 3);
    pulse_req(4'b0011);
    grant(0, 2);
    grant(1, 2);

    // 3: coalescing on a pending bit
    pulse_req(4'b0001);
    wait_pulse(t);
    chk("t3_id0", o_ch_id, 0);
    req = 4'b0100;
    @(negedge clk);
    chk("t3_pend2", o_pend[2], 1);
    chk("t3_merge_a", o_merge, 0);
    @(negedge clk);
    chk("t3_merge_b", o_merge, 1);
    @(negedge clk);
    chk("t3_merge_c", o_merge, 1);
    req = '0;
    @(negedge clk);
    chk("t3_merge_d", o_merge, 0);
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    grant(2, 1);
    p0 = n_pulses;
    repeat (40) @(negedge clk);
    chk("t3_no_regrant", n_pulses - p0, 0);

    // 4: request on the cycle its bit is granted stays queued
    req = 4'b0010;
    @(negedge clk);
    chk("t4_pend1", o_pend[1], 1);
    @(negedge clk);
    req = '0;
    chk("t4_pulse", o_ch_pulse, 1);
    chk("t4_id", o_ch_id, 1);
    chk("t4_requeued", o_pend[1], 1);
    chk("t4_merge", o_merge, 0);
    @(negedge clk);
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    grant(1, 2);

    // 5: lost ack -> timeout, stray ack in cooldown, next grant spacing
    pulse_req(4'b1000);
    wait_pulse(t);
    chk("t5_id3", o_ch_id, 3);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    tc = 1;
    while (o_tmo_err !== 1'b1 && tc < TMO + 50) begin
      @(negedge clk);
      tc++;
    end
    chk("t5_tmo_delay", tc, TMO);
    @(negedge clk);
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    wait_pulse(t);
    chk("t5_next_gap", t + 2, COOL + 1);
    chk("t5_id0", o_ch_id, 0);

    // 6: async reset in WAIT_ACK, restart from id 0
    @(negedge clk);
    pulse_req(4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t6_async", {o_pend, o_ch_pulse, o_ch_id, o_busy, o_merge, o_tmo_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_req(4'b1111);
    for (int i = 0; i < 4; i++) grant(i, 1);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 5) == 0) ? NR'($urandom) : '0;
      ack = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    req = '0; ack = 1'b0;
    repeat (60) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
